// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Front-end sequencing for the RV32I core: drives the PC write enable and
//   the IF/ID and decode-stage clk_en/flush controls. It inserts load-use
//   bubbles, squashes wrong-path fetches after a taken branch/jump, freezes
//   the front end while data memory is busy, counts stall cycles
//   (saturating) and raises a sticky flag when a memory wait runs too long.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_id_rs1/rs2, i_id_uses_rs1/rs2   source operands of the IF/ID instruction
//   i_ex_mem_rd, i_ex_reg_destination  load indication and rd held in ID/EX
//   i_ex_redirect            taken branch / jump resolved in EX
//   i_dmem_req, i_dmem_ready MA-stage data memory handshake
//   o_pc_wr, o_if_clk_en, o_if_flush, o_id_clk_en, o_id_flush  pipeline controls
//   o_state                  FSM state (RUN=00, REDIRECT=01, MEM_WAIT=10)
//   o_stall_count            cycles with o_pc_wr low, saturating
//   o_mem_timeout            sticky memory-wait timeout
module pipeline_hazard_controller #(
  parameter int REG_ADDR    = 5,
  parameter int IMEM_LAT    = 1,
  parameter int MAX_WAIT    = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR-1:0]    i_id_rs1,
  input  logic [REG_ADDR-1:0]    i_id_rs2,
  input  logic                   i_id_uses_rs1,
  input  logic                   i_id_uses_rs2,
  input  logic                   i_ex_mem_rd,
  input  logic [REG_ADDR-1:0]    i_ex_reg_destination,
  input  logic                   i_ex_redirect,
  input  logic                   i_dmem_req,
  input  logic                   i_dmem_ready,
  output logic                   o_pc_wr,
  output logic                   o_if_clk_en,
  output logic                   o_if_flush,
  output logic                   o_id_clk_en,
  output logic                   o_id_flush,
  output logic [1:0]             o_state,
  output logic [STALL_CNT_W-1:0] o_stall_count,
  output logic                   o_mem_timeout
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    REDIRECT = 2'b01,
    MEM_WAIT = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam int WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  state_t            pre_q, pre_d;     // state to resume once memory wait ends
  state_t            eff;              // state whose rules apply this cycle
  logic [2:0]        redir_q, redir_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic              to_q;
  logic              freeze, hazard, wait_max;

  assign freeze   = i_dmem_req & ~i_dmem_ready;
  assign hazard   = i_ex_mem_rd & (i_ex_reg_destination != '0) &
                    ((i_id_uses_rs1 & (i_id_rs1 == i_ex_reg_destination)) |
                     (i_id_uses_rs2 & (i_id_rs2 == i_ex_reg_destination)));
  assign wait_max = (wait_q == WC_W'(MAX_WAIT));

  // MEM_WAIT behaves like the state it interrupted; the illegal code runs
  // as RUN so the next edge lands in a legal state.
  always_comb begin
    case (state_q)
      MEM_WAIT: eff = pre_q;
      ILLEGAL:  eff = RUN;
      default:  eff = state_q;
    endcase
  end

  always_comb begin
    o_pc_wr     = 1'b1;
    o_if_clk_en = 1'b1;
    o_if_flush  = 1'b0;
    o_id_clk_en = 1'b1;
    o_id_flush  = 1'b0;
    state_d     = eff;
    pre_d       = pre_q;
    redir_d     = redir_q;
    wait_d      = '0;
    if (rst) begin
      o_pc_wr    = 1'b0;
      o_if_flush = 1'b1;
      o_id_flush = 1'b1;
    end else if (freeze) begin
      o_pc_wr     = 1'b0;
      o_if_clk_en = 1'b0;
      o_id_clk_en = 1'b0;
      state_d     = MEM_WAIT;
      if (state_q != MEM_WAIT) pre_d = eff;
      // saturate so a very long wait cannot wrap back below MAX_WAIT
      wait_d      = wait_max ? wait_q : wait_q + WC_W'(1);
    end else if (i_ex_redirect) begin
      o_if_flush = 1'b1;
      o_id_flush = 1'b1;
      if (IMEM_LAT > 0) begin
        state_d = REDIRECT;
        redir_d = 3'(IMEM_LAT);
      end else begin
        state_d = RUN;
      end
    end else if (eff == REDIRECT) begin
      // fetch output still invalid: keep loading NOPs into IF/ID
      o_if_flush = 1'b1;
      redir_d    = redir_q - 3'd1;
      state_d    = (redir_q <= 3'd1) ? RUN : REDIRECT;
    end else if (hazard) begin
      o_pc_wr     = 1'b0;
      o_if_clk_en = 1'b0;
      o_id_flush  = 1'b1;
      state_d     = RUN;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pre_q   <= RUN;
      redir_q <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      redir_q <= redir_d;
      wait_q  <= wait_d;
      if (!o_pc_wr && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
      if (freeze && wait_max) to_q <= 1'b1;
    end
  end

  assign o_state       = state_q;
  assign o_stall_count = stall_q;
  assign o_mem_timeout = to_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;
  localparam int RA  = 5;
  localparam int LAT = 1;
  localparam int MW  = 15;
  localparam int SCW = 5;
  localparam int SAT = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RA-1:0] rs1 = '0, rs2 = '0, ex_rd = '0;
  logic u1 = 0, u2 = 0, mem_rd = 0, redir = 0, dreq = 0, drdy = 0;
  logic pc_wr, if_en, if_fl, id_en, id_fl, to;
  logic [1:0] st;
  logic [SCW-1:0] scnt;

  int total = 0;
  int bad = 0;
  logic chk_en = 0;

  pipeline_hazard_controller #(.REG_ADDR(RA), .IMEM_LAT(LAT), .MAX_WAIT(MW),
                               .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_ex_mem_rd(mem_rd), .i_ex_reg_destination(ex_rd), .i_ex_redirect(redir),
    .i_dmem_req(dreq), .i_dmem_ready(drdy),
    .o_pc_wr(pc_wr), .o_if_clk_en(if_en), .o_if_flush(if_fl),
    .o_id_clk_en(id_en), .o_id_flush(id_fl), .o_state(st),
    .o_stall_count(scnt), .o_mem_timeout(to));

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: pending redirect cycles, consecutive frozen cycles,
  // whether we are parked waiting on memory, stall count, sticky timeout.
  int  m_redir_left = 0;
  int  m_frozen = 0;
  bit  m_waiting = 0;
  int  m_stall = 0;
  bit  m_to = 0;

  always @(negedge clk) begin
    bit frz, hz;
    int e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_st;
    if (chk_en) begin
      frz  = dreq && !drdy;
      hz   = mem_rd && (ex_rd != 0) && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
      e_st = m_waiting ? 2 : (m_redir_left > 0 ? 1 : 0);
      if (rst)                   {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd0,32'd1,32'd1,32'd1,32'd1};
      else if (frz)              {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd0,32'd0,32'd0,32'd0,32'd0};
      else if (redir)            {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd1,32'd1,32'd1,32'd1,32'd1};
      else if (m_redir_left > 0) {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd1,32'd1,32'd1,32'd1,32'd0};
      else if (hz)               {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd0,32'd0,32'd0,32'd1,32'd1};
      else                       {e_pc,e_ifen,e_iffl,e_iden,e_idfl} = {32'd1,32'd1,32'd0,32'd1,32'd0};
      chk("pc_wr", int'(pc_wr), e_pc);
      chk("if_clk_en", int'(if_en), e_ifen);
      chk("if_flush", int'(if_fl), e_iffl);
      chk("id_clk_en", int'(id_en), e_iden);
      chk("id_flush", int'(id_fl), e_idfl);
      chk("state", int'(st), e_st);
      chk("stall_count", int'(scnt), m_stall);
      chk("mem_timeout", int'(to), int'(m_to));
      if (rst) begin
        m_redir_left = 0; m_frozen = 0; m_waiting = 0; m_stall = 0; m_to = 0;
      end else begin
        if (e_pc == 0 && m_stall < SAT) m_stall++;
        if (frz) begin
          if (m_frozen >= MW) m_to = 1;
          m_frozen++;
          m_waiting = 1;
        end else begin
          m_frozen  = 0;
          m_waiting = 0;
          if (redir) m_redir_left = LAT;
          else if (m_redir_left > 0) m_redir_left--;
        end
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    rst = 0; u1 = 0; u2 = 0; mem_rd = 0; redir = 0; dreq = 0; drdy = 0;
    rs1 = '0; rs2 = '0; ex_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(1); rst = 0;
  endtask

  initial begin
    // reset
    rst = 1;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_pc_wr", int'(pc_wr), 0);
    chk("rst_if_flush", int'(if_fl), 1);
    chk("rst_id_flush", int'(id_fl), 1);
    chk("rst_state", int'(st), 0);
    cyc(1);
    idle(); cyc(2);

    // load-use hazard on rs1, then bubble clears mem_rd
    mem_rd = 1; ex_rd = 5; rs1 = 5; u1 = 1;
    @(negedge clk);
    chk("hz_pc_wr", int'(pc_wr), 0);
    chk("hz_if_en", int'(if_en), 0);
    chk("hz_id_flush", int'(id_fl), 1);
    cyc(1); mem_rd = 0;
    @(negedge clk);
    chk("hz_after_pc_wr", int'(pc_wr), 1);
    cyc(1);
    // rd == x0 never stalls
    mem_rd = 1; ex_rd = 0; rs1 = 0;
    @(negedge clk);
    chk("hz_x0_pc_wr", int'(pc_wr), 1);
    cyc(1);
    // rs2 match, and match with use flag clear
    ex_rd = 9; rs2 = 9; u2 = 1; cyc(1);
    u2 = 0; cyc(1);
    idle(); cyc(1);

    // redirect pulse
    redir = 1;
    @(negedge clk);
    chk("rd_t_if_flush", int'(if_fl), 1);
    chk("rd_t_id_flush", int'(id_fl), 1);
    chk("rd_t_pc_wr", int'(pc_wr), 1);
    cyc(1); redir = 0;
    mem_rd = 1; ex_rd = 3; rs1 = 3; u1 = 1;  // hazard ignored in REDIRECT
    @(negedge clk);
    chk("rd_t1_state", int'(st), 1);
    chk("rd_t1_if_flush", int'(if_fl), 1);
    chk("rd_t1_pc_wr", int'(pc_wr), 1);
    cyc(1); idle();
    @(negedge clk);
    chk("rd_t2_state", int'(st), 0);
    cyc(1);

    // 3-cycle memory freeze
    do_reset(); idle();
    dreq = 1; drdy = 0; cyc(3);
    drdy = 1;
    @(negedge clk);
    chk("mw_stall_count", int'(scnt), 3);
    chk("mw_state", int'(st), 2);
    chk("mw_release_pc_wr", int'(pc_wr), 1);
    cyc(1); idle(); cyc(1);

    // timeout after 16 frozen cycles
    dreq = 1; drdy = 0; cyc(15);
    @(negedge clk);
    chk("to_before", int'(to), 0);
    cyc(1);
    @(negedge clk);
    chk("to_set", int'(to), 1);
    chk("to_still_frozen", int'(pc_wr), 0);
    drdy = 1; cyc(2); idle(); cyc(1);
    @(negedge clk);
    chk("to_sticky", int'(to), 1);
    cyc(1);

    // freeze + redirect + hazard together, then release
    do_reset(); idle();
    dreq = 1; drdy = 0; redir = 1; mem_rd = 1; ex_rd = 7; rs1 = 7; u1 = 1;
    @(negedge clk);
    chk("frh_if_flush", int'(if_fl), 0);
    chk("frh_id_flush", int'(id_fl), 0);
    cyc(2);
    drdy = 1;
    @(negedge clk);
    chk("frh_rel_id_flush", int'(id_fl), 1);
    chk("frh_rel_pc_wr", int'(pc_wr), 1);
    cyc(1); redir = 0; dreq = 0;
    // freeze arriving in REDIRECT state resumes REDIRECT afterwards
    dreq = 1; drdy = 0; cyc(2);
    drdy = 1;
    @(negedge clk);
    chk("frr_resume_if_flush", int'(if_fl), 1);
    cyc(1); idle(); cyc(2);

    // stall counter saturation
    dreq = 1; drdy = 0; cyc(40);
    @(negedge clk);
    chk("stall_sat", int'(scnt), SAT);
    cyc(1);

    // reset in MEM_WAIT
    rst = 1; cyc(1); rst = 0; idle();
    @(negedge clk);
    chk("rmw_state", int'(st), 0);
    chk("rmw_stall", int'(scnt), 0);
    chk("rmw_to", int'(to), 0);
    cyc(1);

    // mixed vectors for model coverage
    for (int i = 0; i < 300; i++) begin
      dreq   = ($urandom_range(0, 3) == 0);
      drdy   = ($urandom_range(0, 1) == 0);
      redir  = ($urandom_range(0, 5) == 0);
      mem_rd = ($urandom_range(0, 1) == 0);
      ex_rd  = RA'($urandom_range(0, 3));
      rs1    = RA'($urandom_range(0, 3));
      rs2    = RA'($urandom_range(0, 3));
      u1     = $urandom_range(0, 1) != 0;
      u2     = $urandom_range(0, 1) != 0;
      rst    = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    idle(); cyc(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
